// File: rtl/vector_sweep_checker.sv
// Exhaustive stimulus engine for a small combinational gate: walks every input
// vector, holds it for DWELL cycles, and checks the sampled output against EXPECT.
module vector_sweep_checker #(
    parameter int unsigned               N_IN   = 5,
    parameter int unsigned               DWELL  = 10,
    parameter logic [(2**N_IN)-1:0]      EXPECT = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    input  logic              dut_f,
    output logic [N_IN-1:0]   stim,
    output logic              busy,
    output logic              done,
    output logic              pass,
    output logic [N_IN:0]     err_count,
    output logic [N_IN-1:0]   first_fail_vec,
    output logic              first_fail_valid
);

    localparam int unsigned     CW        = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0]   CNT_LAST  = CW'(DWELL - 1);
    localparam logic [N_IN-1:0] STIM_LAST = '1;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    logic [1:0]      state_q, state_d;
    logic [N_IN-1:0] stim_q, stim_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [N_IN:0]   err_q, err_d;
    logic [N_IN-1:0] ffv_q, ffv_d;
    logic            ffvalid_q, ffvalid_d;
    logic            mismatch;

    always_comb begin
        state_d   = state_q;
        stim_d    = stim_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        ffv_d     = ffv_q;
        ffvalid_d = ffvalid_q;
        mismatch  = 1'b0;
        case (state_q)
            ST_RUN: begin
                // Abort takes priority over the sample on the same edge.
                if (abort) begin
                    state_d = ST_IDLE;
                    stim_d  = '0;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    mismatch = (dut_f !== EXPECT[stim_q]);
                    if (mismatch) begin
                        err_d = err_q + 1'b1;
                        if (!ffvalid_q) begin
                            ffv_d     = stim_q;
                            ffvalid_d = 1'b1;
                        end
                    end
                    cnt_d = '0;
                    if (stim_q == STIM_LAST) begin
                        state_d = ST_DONE;
                    end else begin
                        stim_d = stim_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    state_d   = ST_RUN;
                    stim_d    = '0;
                    cnt_d     = '0;
                    err_d     = '0;
                    ffv_d     = '0;
                    ffvalid_d = 1'b0;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            stim_q    <= '0;
            cnt_q     <= '0;
            err_q     <= '0;
            ffv_q     <= '0;
            ffvalid_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            stim_q    <= stim_d;
            cnt_q     <= cnt_d;
            err_q     <= err_d;
            ffv_q     <= ffv_d;
            ffvalid_q <= ffvalid_d;
        end
    end

    assign stim             = stim_q;
    assign busy             = (state_q == ST_RUN);
    assign done             = (state_q == ST_DONE);
    assign pass             = done && (err_q == '0);
    assign err_count        = err_q;
    assign first_fail_vec   = ffv_q;
    assign first_fail_valid = ffvalid_q;

endmodule

// File: tb/tb_vector_sweep_checker.sv
// Directed bench for vector_sweep_checker: three instances covering the
// 2-input/DWELL=3, 5-input/DWELL=10 and 3-input/DWELL=1 configurations.
module tb_vector_sweep_checker;

    function automatic logic g5(input logic [4:0] v);
        return (v[4] & v[3]) | (v[2] & v[1] & v[0]);
    endfunction

    function automatic logic [31:0] exp5();
        logic [31:0] r;
        r = '0;
        for (int k = 0; k < 32; k++) r[k] = g5(5'(k));
        return r;
    endfunction

    localparam logic [31:0] EXP5 = exp5();

    logic clk = 1'b0;
    logic rst;
    logic [2:0] start_v, abort_v;
    int mode_a, mode_c;

    logic [1:0] stim_a;  logic busy_a, done_a, pass_a, ffvalid_a, f_a;
    logic [2:0] err_a;   logic [1:0] ffv_a;
    logic [4:0] stim_b;  logic busy_b, done_b, pass_b, ffvalid_b, f_b;
    logic [5:0] err_b;   logic [4:0] ffv_b;
    logic [2:0] stim_c;  logic busy_c, done_c, pass_c, ffvalid_c, f_c;
    logic [3:0] err_c;   logic [2:0] ffv_c;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    always_comb begin
        case (mode_a)
            0:       f_a = stim_a[1] & stim_a[0];
            1:       f_a = stim_a[1] | stim_a[0];
            2:       f_a = stim_a[1] ^ stim_a[0];
            3:       f_a = ~(stim_a[1] & stim_a[0]);
            default: f_a = 1'b0;
        endcase
    end

    // Gate model with a stuck-at-0 fault on vector 00111 only.
    assign f_b = (stim_b == 5'b00111) ? 1'b0 : g5(stim_b);
    // mode_c 0: majority (matches EXPECT); 1: AND3 (faulty).
    assign f_c = (mode_c == 0) ? ((stim_c[2] & stim_c[1]) | (stim_c[2] & stim_c[0]) | (stim_c[1] & stim_c[0]))
                               : (&stim_c);

    vector_sweep_checker #(.N_IN(2), .DWELL(3), .EXPECT(4'b1000)) u_a (
        .clk(clk), .rst(rst), .start(start_v[0]), .abort(abort_v[0]), .dut_f(f_a),
        .stim(stim_a), .busy(busy_a), .done(done_a), .pass(pass_a), .err_count(err_a),
        .first_fail_vec(ffv_a), .first_fail_valid(ffvalid_a));

    vector_sweep_checker #(.N_IN(5), .DWELL(10), .EXPECT(EXP5)) u_b (
        .clk(clk), .rst(rst), .start(start_v[1]), .abort(abort_v[1]), .dut_f(f_b),
        .stim(stim_b), .busy(busy_b), .done(done_b), .pass(pass_b), .err_count(err_b),
        .first_fail_vec(ffv_b), .first_fail_valid(ffvalid_b));

    vector_sweep_checker #(.N_IN(3), .DWELL(1), .EXPECT(8'b1110_1000)) u_c (
        .clk(clk), .rst(rst), .start(start_v[2]), .abort(abort_v[2]), .dut_f(f_c),
        .stim(stim_c), .busy(busy_c), .done(done_c), .pass(pass_c), .err_count(err_c),
        .first_fail_vec(ffv_c), .first_fail_valid(ffvalid_c));

    function automatic int get_stim(input int i);
        case (i) 0: return int'(stim_a); 1: return int'(stim_b); default: return int'(stim_c); endcase
    endfunction
    function automatic int get_busy(input int i);
        case (i) 0: return int'(busy_a); 1: return int'(busy_b); default: return int'(busy_c); endcase
    endfunction
    function automatic int get_done(input int i);
        case (i) 0: return int'(done_a); 1: return int'(done_b); default: return int'(done_c); endcase
    endfunction
    function automatic int get_err(input int i);
        case (i) 0: return int'(err_a); 1: return int'(err_b); default: return int'(err_c); endcase
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start, then step until done (or abort), tracking the stim sequence.
    task automatic run_sweep(input int inst, input int dwell, input int abort_at,
                             input int restart_at, output int cycles, output bit seq_ok);
        @(negedge clk);
        start_v[inst] = 1'b1;
        @(posedge clk);
        #1 start_v[inst] = 1'b0;
        chk($sformatf("i%0d_entry_busy", inst), get_busy(inst), 1);
        chk($sformatf("i%0d_entry_done", inst), get_done(inst), 0);
        chk($sformatf("i%0d_entry_err", inst), get_err(inst), 0);
        cycles = 0;
        seq_ok = 1'b1;
        while (get_done(inst) == 0 && cycles < 2000) begin
            if (get_stim(inst) != cycles / dwell) seq_ok = 1'b0;
            if (cycles == abort_at) abort_v[inst] = 1'b1;
            if (cycles == restart_at) start_v[inst] = 1'b1;
            @(posedge clk);
            #1;
            abort_v[inst] = 1'b0;
            start_v[inst] = 1'b0;
            cycles++;
            if (abort_at >= 0 && cycles > abort_at) break;
        end
    endtask

    typedef struct {
        int mode;
        int err;
        int ffv;
        int ffvalid;
        int pass;
    } vec_t;

    initial begin
        vec_t tbl[5];
        int   cyc;
        bit   ok;
        int   n;

        tbl[0] = '{mode: 0, err: 0, ffv: 0, ffvalid: 0, pass: 1};
        tbl[1] = '{mode: 1, err: 2, ffv: 1, ffvalid: 1, pass: 0};
        tbl[2] = '{mode: 2, err: 3, ffv: 1, ffvalid: 1, pass: 0};
        tbl[3] = '{mode: 3, err: 4, ffv: 0, ffvalid: 1, pass: 0};
        tbl[4] = '{mode: 4, err: 1, ffv: 3, ffvalid: 1, pass: 0};

        rst = 1'b1; start_v = '0; abort_v = '0; mode_a = 0; mode_c = 1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_stim", int'(stim_a), 0);
        chk("rst_busy", int'(busy_a), 0);
        chk("rst_done", int'(done_a), 0);
        chk("rst_pass", int'(pass_a), 0);
        chk("rst_err", int'(err_a), 0);
        chk("rst_ffv", int'(ffv_a), 0);
        chk("rst_ffvalid", int'(ffvalid_a), 0);
        chk("rst_busy_b", int'(busy_b), 0);
        chk("rst_done_c", int'(done_c), 0);
        @(negedge clk) rst = 1'b0;

        // Full sweeps of the 2-input checker against several gate behaviours.
        for (int i = 0; i < 5; i++) begin
            mode_a = tbl[i].mode;
            run_sweep(0, 3, -1, -1, cyc, ok);
            chk($sformatf("row%0d_cycles", i), cyc, 12);
            chk($sformatf("row%0d_seq", i), int'(ok), 1);
            chk($sformatf("row%0d_done", i), int'(done_a), 1);
            chk($sformatf("row%0d_busy", i), int'(busy_a), 0);
            chk($sformatf("row%0d_stim", i), int'(stim_a), 3);
            chk($sformatf("row%0d_err", i), int'(err_a), tbl[i].err);
            chk($sformatf("row%0d_ffv", i), int'(ffv_a), tbl[i].ffv);
            chk($sformatf("row%0d_ffvalid", i), int'(ffvalid_a), tbl[i].ffvalid);
            chk($sformatf("row%0d_pass", i), int'(pass_a), tbl[i].pass);
        end

        // Abort in DONE has no effect.
        @(negedge clk) abort_v[0] = 1'b1;
        @(posedge clk); #1 abort_v[0] = 1'b0;
        chk("abort_done_done", int'(done_a), 1);
        chk("abort_done_err", int'(err_a), 1);

        // Abort after 5 RUN cycles keeps partial results.
        mode_a = 3;
        run_sweep(0, 3, 5, -1, cyc, ok);
        chk("abort_busy", int'(busy_a), 0);
        chk("abort_done", int'(done_a), 0);
        chk("abort_stim", int'(stim_a), 0);
        chk("abort_err", int'(err_a), 1);
        chk("abort_ffvalid", int'(ffvalid_a), 1);
        chk("abort_ffv", int'(ffv_a), 0);
        chk("abort_pass", int'(pass_a), 0);

        // Abort and start together in RUN: abort wins.
        run_sweep(0, 3, 5, 5, cyc, ok);
        chk("abst_busy", int'(busy_a), 0);
        @(posedge clk); #1;
        chk("abst_idle_busy", int'(busy_a), 0);
        chk("abst_idle_stim", int'(stim_a), 0);

        // Start re-pulsed during RUN is ignored.
        mode_a = 1;
        run_sweep(0, 3, -1, 4, cyc, ok);
        chk("restart_cycles", cyc, 12);
        chk("restart_seq", int'(ok), 1);
        chk("restart_err", int'(err_a), 2);
        chk("restart_ffv", int'(ffv_a), 1);

        // Asynchronous reset mid-sweep at stim=2.
        mode_a = 3;
        @(negedge clk) start_v[0] = 1'b1;
        @(posedge clk); #1 start_v[0] = 1'b0;
        n = 0;
        while (stim_a != 2'd2 && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        chk("midrst_reach_stim2", int'(stim_a), 2);
        rst = 1'b1;
        #1;
        chk("midrst_stim", int'(stim_a), 0);
        chk("midrst_busy", int'(busy_a), 0);
        chk("midrst_done", int'(done_a), 0);
        chk("midrst_err", int'(err_a), 0);
        chk("midrst_ffvalid", int'(ffvalid_a), 0);
        chk("midrst_ffv", int'(ffv_a), 0);
        @(negedge clk) rst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("postrst_busy", int'(busy_a), 0);
        chk("postrst_stim", int'(stim_a), 0);
        mode_a = 0;
        run_sweep(0, 3, -1, -1, cyc, ok);
        chk("postrst_cycles", cyc, 12);
        chk("postrst_seq", int'(ok), 1);
        chk("postrst_pass", int'(pass_a), 1);
        chk("postrst_err", int'(err_a), 0);

        // 5-input gate with a single stuck-at fault.
        run_sweep(1, 10, -1, -1, cyc, ok);
        chk("n5_cycles", cyc, 320);
        chk("n5_seq", int'(ok), 1);
        chk("n5_done", int'(done_b), 1);
        chk("n5_err", int'(err_b), 1);
        chk("n5_ffv", int'(ffv_b), 7);
        chk("n5_ffvalid", int'(ffvalid_b), 1);
        chk("n5_pass", int'(pass_b), 0);
        chk("n5_stim", int'(stim_b), 31);

        // DWELL=1: a new vector every cycle; then rerun from DONE.
        mode_c = 1;
        run_sweep(2, 1, -1, -1, cyc, ok);
        chk("d1_cycles", cyc, 8);
        chk("d1_seq", int'(ok), 1);
        chk("d1_err", int'(err_c), 3);
        chk("d1_ffv", int'(ffv_c), 3);
        chk("d1_pass", int'(pass_c), 0);
        mode_c = 0;
        run_sweep(2, 1, -1, -1, cyc, ok);
        chk("d1r_cycles", cyc, 8);
        chk("d1r_seq", int'(ok), 1);
        chk("d1r_err", int'(err_c), 0);
        chk("d1r_ffvalid", int'(ffvalid_c), 0);
        chk("d1r_pass", int'(pass_c), 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/vector_sweep_checker.md
Name: vector_sweep_checker

Overview:
- Parametrised, self-checking exhaustive stimulus engine for small combinational gates.
- Replaces hand-written per-gate vector lists: walks every N_IN-bit input combination, holds each for a programmable dwell, samples the gate output and compares it against a truth table given as a parameter.
- Reports mismatch count and first failing vector.
- Sits beside a gate DUT in lab benches and on-board checkers. Synthesisable.

Parameters:
N_IN, 5, number of DUT inputs; vectors 0 .. 2^N_IN-1 are swept.
DWELL, 10, clock cycles each vector is held (minimum 1).
EXPECT, 0 (width 2^N_IN), expected truth table; bit k is the expected output for stimulus value k.

Ports:
clk  input  1  system clock, rising edge.
rst  input  1  asynchronous, active-high reset.
start  input  1  one-cycle request to begin a sweep; honoured only in IDLE or DONE.
abort  input  1  stop the sweep and return to IDLE.
dut_f  input  1  DUT output under test.
stim  output  N_IN  vector driven to the DUT; MSB maps to the first DUT input (A).
busy  output  1  high while sweeping.
done  output  1  high from sweep completion until the next start or reset.
pass  output  1  equals done AND (err_count == 0).
err_count  output  N_IN+1  number of mismatching vectors in the current or last sweep.
first_fail_vec  output  N_IN  stimulus value of the first mismatch.
first_fail_valid  output  1  first_fail_vec holds a captured value.

Behaviour:
- Reset values (asynchronous, immediate on rst high): state IDLE, stim 0, dwell counter 0, busy 0, done 0, pass 0, err_count 0, first_fail_vec 0, first_fail_valid 0.
- States: IDLE, RUN, DONE.
- IDLE or DONE with start=1:
  - Next edge enters RUN with stim=0 and dwell counter 0.
  - Clears err_count, first_fail_valid, first_fail_vec and done.
  - Sets busy.
- RUN, dwell handling:
  - Dwell counter increments each cycle.
  - On the edge where the counter equals DWELL-1, dut_f is sampled and compared with EXPECT[stim].
  - Mismatch: err_count increments. If first_fail_valid=0, latch first_fail_vec=stim and set first_fail_valid.
  - Simulation only: dut_f of X or Z counts as a mismatch (case-inequality compare).
- RUN, vector advance (same sample edge):
  - If stim < 2^N_IN-1: stim increments and the counter resets to 0.
  - If stim = 2^N_IN-1: next state DONE, busy 0, done 1, stim holds its final value.
  - No wrap-around of stim.
- Sweep latency: exactly 2^N_IN × DWELL cycles in RUN. done is first high on the cycle after the last sample edge.
- err_count saturates by construction: its maximum is 2^N_IN, which fits N_IN+1 bits.
- start while in RUN is ignored; no restart.
- abort:
  - In RUN: next state IDLE, busy 0, done 0, stim 0. err_count and first_fail fields keep partial results.
  - abort and start in the same cycle: abort wins.
  - abort in IDLE or DONE: no effect.
- DWELL=1: a new vector every cycle; the sample edge coincides with each advance.
- rst mid-sweep: everything returns to reset values immediately. No sweep resumes after rst falls until a new start.

Test Plan:
1. N_IN=2, DWELL=3, EXPECT=4'b1000, DUT = A&B. Pulse start → stim 0,1,2,3 each held 3 cycles; done high 12 cycles after RUN entry; pass=1; err_count=0; first_fail_valid=0.
2. Same parameters, DUT = A|B. Full sweep → err_count=2; first_fail_vec=2'b01; first_fail_valid=1; pass=0; done=1.
3. N_IN=5, DWELL=10, EXPECT matched to the 5-input gate model, DUT output stuck-at-0 on vector 5'b00111 only. Full sweep → 320 RUN cycles; err_count=1; first_fail_vec=5'b00111.
4. Abort after 5 RUN cycles (N_IN=2, DWELL=3). → busy 0, done 0, stim 0 next edge. Start re-pulsed during RUN of a second sweep is ignored: stim sequence unbroken.
5. rst asserted at stim=2 mid-sweep → all outputs 0 asynchronously. After release, start → fresh sweep from stim=0 with err_count cleared.
6. DWELL=1, N_IN=3 → stim increments every cycle, 8-cycle sweep. Start pulsed in DONE clears done and err_count and reruns.
